// File: rtl/gameconsole_pkg.sv
// Shared types for the video capture block.
// Capture FSM states, screen geometry and the pixel FIFO entry layout.
package gameconsole_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int SKIP_W   = 16;

  typedef enum logic [2:0] {
    CAP_IDLE,
    CAP_WAIT_VS,
    CAP_CAPTURE,
    CAP_DRAIN,
    CAP_DONE
  } capture_state_e;

  // skip = pixels dropped just before this one
  typedef struct packed {
    logic [SKIP_W-1:0] skip;
    logic [31:0]       color;
  } pix_entry_t;

  function automatic logic [31:0] skip_addr(
    input logic [31:0]       addr,
    input logic [SKIP_W-1:0] skip
  );
    return addr + {14'b0, skip, 2'b00};
  endfunction

endpackage

// File: rtl/video_capture_fifo.sv
// Synchronous pixel FIFO, DEPTH entries (power of 2), W bits wide.
// Ports: push/push_data in, pop/pop_data out (show-ahead), full/empty/count.
module video_capture_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 48,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/video_capture.sv
// Captures one frame of the dot_clk/color/hsync/vsync stream into memory.
// Ports: start/base_addr/busy/done/overflow control, video in, mem_* writer.
module video_capture
  import gameconsole_pkg::*;
#(
  parameter int H_ACTIVE   = SCREEN_W,
  parameter int V_ACTIVE   = SCREEN_H,
  parameter int H_BP       = 0,
  parameter int V_BP       = 0,
  parameter int SYNC_LOW   = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  input  logic        dot_clk,
  input  logic [31:0] color,
  input  logic        hsync,
  input  logic        vsync,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic        mem_ready
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [31:0] X_LO  = 32'(H_BP);
  localparam logic [31:0] Y_LO  = 32'(V_BP);
  localparam logic [31:0] X_N   = 32'(H_ACTIVE);
  localparam logic [31:0] Y_N   = 32'(V_ACTIVE);
  localparam logic [31:0] TOTAL = 32'(H_ACTIVE * V_ACTIVE);
  localparam logic        SL    = (SYNC_LOW != 0);

  // input stage
  logic        dot_q;
  logic        dot_d;
  logic        hs_q;
  logic        vs_q;
  logic [31:0] color_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dot_q   <= 1'b0;
      dot_d   <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      color_q <= '0;
    end else begin
      dot_q   <= dot_clk;
      dot_d   <= dot_q;
      hs_q    <= hsync;
      vs_q    <= vsync;
      color_q <= color;
    end
  end

  logic pix_edge;
  logic hs_act;
  logic vs_act;

  assign pix_edge = dot_q & ~dot_d;
  assign hs_act   = hs_q ^ SL;
  assign vs_act   = vs_q ^ SL;

  // raster position, sampled on pixel edges only
  logic        hs_last;
  logic        vs_last;
  logic        line_seen;
  logic [31:0] x_cnt;
  logic [31:0] y_cnt;

  logic        hs_fall;
  logic        vs_fall;
  logic        vs_rise;
  logic        line_seen_n;
  logic [31:0] x_cur;
  logic [31:0] y_cur;
  logic        active;

  // line_seen keeps a vsync that ends mid-line from
  // making the partial line row 0
  always_comb begin
    hs_fall     = pix_edge & hs_last & ~hs_act;
    vs_fall     = pix_edge & vs_last & ~vs_act;
    vs_rise     = pix_edge & ~vs_last & vs_act;
    x_cur       = hs_fall ? '0 : x_cnt;
    y_cur       = y_cnt;
    line_seen_n = line_seen;
    if (vs_fall) begin
      y_cur       = '0;
      line_seen_n = hs_fall;
    end else if (hs_fall) begin
      if (line_seen) y_cur = y_cnt + 1'b1;
      line_seen_n = 1'b1;
    end
    active = pix_edge & ~hs_act & ~vs_act & line_seen_n
           & ((x_cur - X_LO) < X_N)
           & ((y_cur - Y_LO) < Y_N);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_last   <= 1'b0;
      vs_last   <= 1'b0;
      line_seen <= 1'b0;
      x_cnt     <= '0;
      y_cnt     <= '0;
    end else if (pix_edge) begin
      hs_last   <= hs_act;
      vs_last   <= vs_act;
      line_seen <= line_seen_n;
      x_cnt     <= x_cur + 1'b1;
      y_cnt     <= y_cur;
    end
  end

  // capture control
  capture_state_e state;
  capture_state_e state_n;

  logic              start_acc;
  logic              take;
  logic              last_pix;
  logic [31:0]       pix_cnt;
  logic [SKIP_W-1:0] drop_run;
  logic [31:0]       addr;

  pix_entry_t    fifo_in;
  pix_entry_t    fifo_out;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW:0]   fifo_count;
  logic          drop;
  logic          wr_active;

  assign start_acc = start
                   && (state == CAP_IDLE || state == CAP_DONE);
  // the vsync-deassert pixel itself can be (0,0)
  assign take      = active
                   && (state == CAP_CAPTURE
                   || (state == CAP_WAIT_VS && vs_fall));
  assign last_pix  = take && (pix_cnt == TOTAL - 1'b1);
  assign fifo_push = take && !fifo_full;
  assign drop      = take && fifo_full;
  assign wr_active = (state == CAP_CAPTURE)
                   || (state == CAP_DRAIN);
  assign fifo_pop  = wr_active && !mem_en && !fifo_empty;
  assign fifo_in   = '{skip: drop_run, color: color_q};
  assign mem_we    = mem_en;

  video_capture_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(pix_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_out),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= CAP_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      CAP_IDLE: begin
        if (start_acc) state_n = CAP_WAIT_VS;
      end
      CAP_WAIT_VS: begin
        if (last_pix)     state_n = CAP_DRAIN;
        else if (vs_fall) state_n = CAP_CAPTURE;
      end
      CAP_CAPTURE: begin
        if (last_pix || vs_rise) state_n = CAP_DRAIN;
      end
      CAP_DRAIN: begin
        if (fifo_count == '0 && !mem_en)
          state_n = CAP_DONE;
      end
      CAP_DONE: begin
        state_n = start_acc ? CAP_WAIT_VS : CAP_IDLE;
      end
      default: state_n = CAP_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      CAP_WAIT_VS,
      CAP_CAPTURE,
      CAP_DRAIN: busy = 1'b1;
      CAP_DONE:  done = 1'b1;
      default:   ;
    endcase
  end

  // counting, drop tracking and the memory writer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_cnt  <= '0;
      drop_run <= '0;
      overflow <= 1'b0;
      addr     <= '0;
      mem_en   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
    end else if (start_acc) begin
      pix_cnt  <= '0;
      drop_run <= '0;
      overflow <= 1'b0;
      addr     <= base_addr;
    end else begin
      if (take) pix_cnt <= pix_cnt + 1'b1;
      if (fifo_push) begin
        drop_run <= '0;
      end else if (drop) begin
        overflow <= 1'b1;
        if (drop_run != '1) drop_run <= drop_run + 1'b1;
      end
      if (fifo_pop) begin
        mem_en   <= 1'b1;
        mem_addr <= skip_addr(addr, fifo_out.skip);
        mem_din  <= fifo_out.color;
      end else if (mem_en && mem_ready) begin
        mem_en <= 1'b0;
        addr   <= mem_addr + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_video_capture.sv
// Scoreboard bench for video_capture on a 4x2 frame.
// Three instances: plain, FIFO_DEPTH=2, and H_BP=2/V_BP=1.
module tb_video_capture;

  localparam int HA = 4;
  localparam int VA = 2;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dot_clk = 1'b0;
  logic [31:0] color = '0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;

  always #5 clk = ~clk;

  logic start_a = 0, start_b = 0, start_c = 0;
  logic rdy_a = 1, rdy_b = 1, rdy_c = 1;
  logic [31:0] base_a = '0, base_b = '0, base_c = '0;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;
  logic ovf_a, ovf_b, ovf_c;
  logic en_a, en_b, en_c;
  logic we_a, we_b, we_c;
  logic [31:0] addr_a, addr_b, addr_c;
  logic [31:0] din_a, din_b, din_c;

  video_capture #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BP(0), .V_BP(0),
    .SYNC_LOW(1), .FIFO_DEPTH(16)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .base_addr(base_a), .busy(busy_a), .done(done_a),
    .overflow(ovf_a), .dot_clk(dot_clk), .color(color),
    .hsync(hsync), .vsync(vsync), .mem_en(en_a),
    .mem_we(we_a), .mem_addr(addr_a), .mem_din(din_a),
    .mem_ready(rdy_a)
  );

  video_capture #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BP(0), .V_BP(0),
    .SYNC_LOW(1), .FIFO_DEPTH(2)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .base_addr(base_b), .busy(busy_b), .done(done_b),
    .overflow(ovf_b), .dot_clk(dot_clk), .color(color),
    .hsync(hsync), .vsync(vsync), .mem_en(en_b),
    .mem_we(we_b), .mem_addr(addr_b), .mem_din(din_b),
    .mem_ready(rdy_b)
  );

  video_capture #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BP(2), .V_BP(1),
    .SYNC_LOW(1), .FIFO_DEPTH(16)
  ) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c),
    .base_addr(base_c), .busy(busy_c), .done(done_c),
    .overflow(ovf_c), .dot_clk(dot_clk), .color(color),
    .hsync(hsync), .vsync(vsync), .mem_en(en_c),
    .mem_we(we_c), .mem_addr(addr_c), .mem_din(din_c),
    .mem_ready(rdy_c)
  );

  int checks = 0;
  int errors = 0;

  wr_t q_a[$];
  wr_t q_c[$];
  logic [31:0] exp_b [logic [31:0]];
  wr_t ea, ec;

  int wr_cnt_a = 0, wr_cnt_b = 0, wr_cnt_c = 0;
  int dn_a = 0, dn_b = 0, dn_c = 0;
  int snap_a = 0, snap_b = 0, snap_c = 0;

  // frame visible area: 4 rows x 8 cols after sync
  logic [31:0] pix [4][8];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%h required=none", nm, act);
  endtask

  // monitors
  always @(negedge clk) begin
    if (rst_n) begin
      if (en_a && rdy_a) begin
        if (q_a.size() == 0) begin
          fail("a_unexpected_write", addr_a);
        end else begin
          ea = q_a.pop_front();
          check("a_addr", addr_a, ea.addr);
          check("a_data", din_a, ea.data);
        end
        wr_cnt_a++;
      end
      if (en_c && rdy_c) begin
        if (q_c.size() == 0) begin
          fail("c_unexpected_write", addr_c);
        end else begin
          ec = q_c.pop_front();
          check("c_addr", addr_c, ec.addr);
          check("c_data", din_c, ec.data);
        end
        wr_cnt_c++;
      end
      if (en_b && rdy_b) begin
        if (exp_b.exists(addr_b)) begin
          check("b_data", din_b, exp_b[addr_b]);
          exp_b.delete(addr_b);
        end else begin
          fail("b_write_addr", addr_b);
        end
        wr_cnt_b++;
      end
      if (done_a) dn_a++;
      if (done_b) dn_b++;
      if (done_c) dn_c++;
    end
  end

  // stall instance A on its third write for 10 cycles
  bit stall_en = 0;
  bit stalled = 0;
  logic [31:0] hold_addr, hold_din;

  always begin
    @(posedge clk);
    #1;
    if (stall_en && !stalled && en_a && wr_cnt_a == 2) begin
      hold_addr = addr_a;
      hold_din  = din_a;
      rdy_a = 1'b0;
      repeat (10) begin
        @(posedge clk);
        #1;
        check("stall_en", en_a, 1);
        check("stall_addr", addr_a, hold_addr);
        check("stall_din", din_a, hold_din);
      end
      rdy_a = 1'b1;
      stalled = 1'b1;
    end
  end

  task automatic gen_frame();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++)
        pix[r][c] = $urandom;
  endtask

  // pixel i of the captured frame lands at base + 4*i
  task automatic push_a(input logic [31:0] base);
    for (int i = 0; i < HA * VA; i++)
      q_a.push_back('{addr: base + 32'(4 * i),
                      data: pix[i / HA][i % HA]});
  endtask

  task automatic push_b(input logic [31:0] base);
    for (int i = 0; i < HA * VA; i++)
      exp_b[base + 32'(4 * i)] = pix[i / HA][i % HA];
  endtask

  task automatic push_c(input logic [31:0] base);
    for (int i = 0; i < HA * VA; i++)
      q_c.push_back('{addr: base + 32'(4 * i),
                      data: pix[1 + i / HA][2 + i % HA]});
  endtask

  task automatic snap();
    snap_a = dn_a;
    snap_b = dn_b;
    snap_c = dn_c;
  endtask

  // 6 lines of 10 dots: lines 0-1 vsync asserted,
  // dots 0-1 of each line hsync asserted (both active-low)
  task automatic send_frame(input int per, input int arm_dot,
                            input bit [2:0] arm_mask,
                            input int rst_dot, input int relb_dot);
    int k;
    k = 0;
    for (int l = 0; l < 6; l++) begin
      for (int d = 0; d < 10; d++) begin
        for (int t = 0; t < per; t++) begin
          @(posedge clk);
          #1;
          start_a = 0;
          start_b = 0;
          start_c = 0;
          if (t == 0) begin
            dot_clk = 1'b1;
            vsync = (l < 2) ? 1'b0 : 1'b1;
            hsync = (d < 2) ? 1'b0 : 1'b1;
            color = (l >= 2 && d >= 2) ? pix[l-2][d-2] : $urandom;
            if (k == arm_dot)
              {start_c, start_b, start_a} = arm_mask;
            if (k == relb_dot) rdy_b = 1'b1;
            if (k == rst_dot) begin
              check("pre_rst_ovf_b", ovf_b, 1);
              check("pre_rst_busy_a", busy_a, 1);
              rst_n = 1'b0;
            end
          end else begin
            dot_clk = 1'b0;
            if (!rst_n) begin
              rst_n = 1'b1;
              q_a.delete();
              q_c.delete();
              exp_b.delete();
              @(negedge clk);
              check("rst_en_a", en_a, 0);
              check("rst_en_b", en_b, 0);
              check("rst_busy_a", busy_a, 0);
              check("rst_busy_b", busy_b, 0);
              check("rst_ovf_b", ovf_b, 0);
            end
          end
        end
        k++;
      end
    end
  endtask

  task automatic settle(input bit [2:0] m);
    repeat (4) @(posedge clk);
    @(negedge clk);
    if (m[0]) begin
      check("a_done_cnt", 32'(dn_a - snap_a), 1);
      check("a_busy_end", busy_a, 0);
      check("a_pending", 32'(q_a.size()), 0);
    end
    if (m[1]) begin
      check("b_done_cnt", 32'(dn_b - snap_b), 1);
      check("b_busy_end", busy_b, 0);
    end
    if (m[2]) begin
      check("c_done_cnt", 32'(dn_c - snap_c), 1);
      check("c_busy_end", busy_c, 0);
      check("c_pending", 32'(q_c.size()), 0);
    end
  endtask

  logic [31:0] mid_base;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy_a, 0);
    check("reset_done", done_a, 0);
    check("reset_ovf", ovf_a, 0);
    check("reset_en", en_a, 0);
    check("reset_we", we_a, 0);
    check("reset_addr", addr_a, 0);
    check("reset_din", din_a, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // warm-up frame, nothing armed
    gen_frame();
    send_frame(4, -1, 3'b000, -1, -1);

    // basic capture on A and back-porch capture on C
    base_a = 32'h1000;
    base_c = 32'h2000;
    gen_frame();
    push_a(base_a);
    push_c(base_c);
    snap();
    send_frame(4, 3, 3'b101, -1, -1);
    settle(3'b101);
    check("a_ovf_clean", ovf_a, 0);
    check("c_ovf_clean", ovf_c, 0);

    // stall on third write, address wraps past 2^32
    base_a = 32'hFFFF_FFF0;
    stall_en = 1;
    stalled = 0;
    wr_cnt_a = 0;
    gen_frame();
    push_a(base_a);
    snap();
    send_frame(4, 3, 3'b001, -1, -1);
    settle(3'b001);
    check("stall_seen", 32'(stalled), 1);
    check("stall_ovf", ovf_a, 0);
    stall_en = 0;

    // start mid-frame: nothing until the next frame
    mid_base = $urandom & 32'hFFFF_FFFC;
    base_a = mid_base;
    gen_frame();
    snap();
    send_frame(4, 35, 3'b001, -1, -1);
    check("mid_busy", busy_a, 1);
    check("mid_no_write", 32'(q_a.size() + dn_a - snap_a), 0);
    gen_frame();
    push_a(mid_base);
    send_frame(4, -1, 3'b000, -1, -1);
    settle(3'b001);

    // fastest dots, depth-2 FIFO stalled 20 cycles
    base_a = 32'h5000;
    base_b = 32'h4000;
    rdy_b = 1'b0;
    wr_cnt_b = 0;
    gen_frame();
    push_a(base_a);
    push_b(base_b);
    snap();
    send_frame(2, 3, 3'b011, -1, 32);
    settle(3'b011);
    check("b_overflow", ovf_b, 1);
    check("a_no_overflow", ovf_a, 0);
    check("b_survivors", 32'(wr_cnt_b > 0 && wr_cnt_b < 8), 1);
    exp_b.delete();

    // reset in the middle of a capture
    base_a = 32'h6000;
    base_b = 32'h6800;
    rdy_b = 1'b0;
    gen_frame();
    push_a(base_a);
    push_b(base_b);
    snap();
    send_frame(4, 3, 3'b011, 30, -1);
    rdy_b = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_no_done_a", 32'(dn_a - snap_a), 0);
    check("rst_no_done_b", 32'(dn_b - snap_b), 0);

    // normal capture after the abort
    base_a = 32'h7000;
    gen_frame();
    push_a(base_a);
    snap();
    send_frame(4, 3, 3'b001, -1, -1);
    settle(3'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
